// File: rtl/strobe_byte_word_rx.sv
// Host byte-strobe receiver: synchronises the strobe, assembles little-endian words
// and hands them off over valid/ready. Optional partial-word timeout: STROBE_RX_TIMEOUT_EN.
module strobe_byte_word_rx #(
  parameter int WORD_BYTES     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    byte_in,
  input  logic                          strobe_in,
  output logic [8*WORD_BYTES-1:0]       word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(WORD_BYTES):0]   byte_count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          timeout
);
  localparam int CW = $clog2(WORD_BYTES) + 1;
  localparam int WW = 8 * WORD_BYTES;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One capture per synchronised rising edge, however long the strobe stays high
  assign cap = sync_q[SYNC_STAGES-1] & ~edge_q;

  logic [WW-1:0] asm_q, asm_d, asm_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          drop;
  logic          to_d;

`ifdef STROBE_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          to_q;
`endif

  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    drop    = 1'b0;
    to_d    = 1'b0;
    asm_nx  = asm_q;
    for (int k = 0; k < WORD_BYTES; k++)
      if (cnt_q == CW'(k)) asm_nx[8*k +: 8] = byte_in;

    if (valid_q && word_ready) valid_d = 1'b0;

    if (cap) begin
      if (cnt_q == CW'(WORD_BYTES - 1)) begin
        cnt_d = '0;
        asm_d = '0;
        if (!valid_q || word_ready) begin
          word_d  = asm_nx;
          valid_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else begin
        asm_d = asm_nx;
        cnt_d = cnt_q + CW'(1);
      end
    end

`ifdef STROBE_RX_TIMEOUT_EN
    idle_d = idle_q;
    if (cap || cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
      idle_d = '0;
      cnt_d  = '0;
      asm_d  = '0;
      to_d   = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end
`endif

    // A drop on the same edge as a clear leaves the flag set
    if (clr_overrun) ovr_d = 1'b0;
    if (drop)        ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef STROBE_RX_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = to_d;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign byte_count = cnt_q;
  assign overrun    = ovr_q;
endmodule
